// File: rtl/xeng_pkg.sv
// -----------------------------------------------------------------------------
// xeng_pkg
// Shared helpers for the X-engine complex-MAC accumulator:
//   - derived widths of the tree sum and of the integrated output
//   - pipeline latency of the product/adder-tree block
//   - bit offsets of the (re, im) parts inside packed vectors
// Packing convention everywhere: element idx occupies
//   [2*idx*width +: 2*width] as {re, im}, so im sits in the LSBs of each pair.
// -----------------------------------------------------------------------------
package xeng_pkg;

  // Width of each part of the tree sum: a full-precision product pair sum
  // (2*bitwidth+1) grown by one bit per adder-tree level.
  function automatic int sum_width(input int bitwidth, input int n_input_bits);
    return 2 * bitwidth + 1 + n_input_bits;
  endfunction

  // Width of each part of the integrated output: one extra bit per doubling
  // of the integration length.
  function automatic int out_width(input int bitwidth, input int n_input_bits,
                                   input int acc_len_bits);
    return sum_width(bitwidth, n_input_bits) + acc_len_bits;
  endfunction

  // Cycles from an in_valid sample to its sum_valid: input register,
  // product register, then one register per adder-tree level.
  function automatic int tree_latency(input int n_input_bits);
    return n_input_bits + 2;
  endfunction

  // LSB of the imaginary part of element idx in a packed {re, im} vector.
  function automatic int im_lsb(input int idx, input int width);
    return 2 * idx * width;
  endfunction

  // LSB of the real part of element idx in a packed {re, im} vector.
  function automatic int re_lsb(input int idx, input int width);
    return (2 * idx + 1) * width;
  endfunction

endpackage

// File: rtl/xeng_cmult_tree.sv
// -----------------------------------------------------------------------------
// xeng_cmult_tree
// Registered complex multiply of N_INPUTS pairs followed by a pipelined
// binary adder tree. Sample -> sum latency is tree_latency(N_INPUT_BITS).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid, in_sync  sample qualifier and window-start marker
//   a, b               N_INPUTS packed {re, im} signed pairs
//   sum_re, sum_im     full-precision tree sum (signed)
//   sum_valid          sum_re/sum_im belong to a valid sample
//   sum_sync           that sample carried in_sync
// -----------------------------------------------------------------------------
module xeng_cmult_tree
  import xeng_pkg::*;
#(
  parameter int BITWIDTH     = 4,
  parameter int N_INPUT_BITS = 3,
  parameter int CONJ_B       = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  input  logic                                           in_sync,
  input  logic [2*BITWIDTH*(1<<N_INPUT_BITS)-1:0]        a,
  input  logic [2*BITWIDTH*(1<<N_INPUT_BITS)-1:0]        b,
  output logic signed [sum_width(BITWIDTH, N_INPUT_BITS)-1:0] sum_re,
  output logic signed [sum_width(BITWIDTH, N_INPUT_BITS)-1:0] sum_im,
  output logic                                           sum_valid,
  output logic                                           sum_sync
);

  localparam int N_INPUTS  = 1 << N_INPUT_BITS;
  localparam int SUM_WIDTH = sum_width(BITWIDTH, N_INPUT_BITS);
  localparam int LAT       = tree_latency(N_INPUT_BITS);
  localparam int VEC_W     = 2 * BITWIDTH * N_INPUTS;
  // Tree stored as a heap: node n has children 2n+1 and 2n+2, leaves are
  // nodes N_INPUTS-1 .. 2*N_INPUTS-2, the root (node 0) is the sum.
  localparam int N_NODES   = 2 * N_INPUTS - 1;

  // Stage 0: input register.
  logic [VEC_W-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of its source, whatever the
      // statement order.
      a_q <= a;
      b_q <= b;
    end
  end

  // Stage 1 combinational part: per-pair complex product, every operand
  // sign-extended to the tree width first so no intermediate can wrap.
  logic signed [SUM_WIDTH-1:0] pair_re [N_INPUTS];
  logic signed [SUM_WIDTH-1:0] pair_im [N_INPUTS];

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_pair
    logic signed [SUM_WIDTH-1:0] ar, ai, br, bi;

    assign ar = SUM_WIDTH'($signed(a_q[re_lsb(i, BITWIDTH) +: BITWIDTH]));
    assign ai = SUM_WIDTH'($signed(a_q[im_lsb(i, BITWIDTH) +: BITWIDTH]));
    assign br = SUM_WIDTH'($signed(b_q[re_lsb(i, BITWIDTH) +: BITWIDTH]));
    assign bi = SUM_WIDTH'($signed(b_q[im_lsb(i, BITWIDTH) +: BITWIDTH]));

    if (CONJ_B != 0) begin : g_conj
      assign pair_re[i] = ar * br + ai * bi;
      assign pair_im[i] = ai * br - ar * bi;
    end else begin : g_plain
      assign pair_re[i] = ar * br - ai * bi;
      assign pair_im[i] = ai * br + ar * bi;
    end
  end

  // Stage 1 register (leaves) and stages 2..N_INPUT_BITS+1 (one tree level
  // per stage). All leaves sit at the same depth, so every node is simply
  // re-registered each cycle from its two children.
  logic signed [SUM_WIDTH-1:0] node_re [N_NODES];
  logic signed [SUM_WIDTH-1:0] node_im [N_NODES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are plain pipeline flops, not RAM, and are cleared
      // so nothing captured before reset can ever reach the accumulator.
      for (int n = 0; n < N_NODES; n++) begin
        node_re[n] <= '0;
        node_im[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_INPUTS - 1; n++) begin
        node_re[n] <= node_re[2*n+1] + node_re[2*n+2];
        node_im[n] <= node_im[2*n+1] + node_im[2*n+2];
      end
      for (int i = 0; i < N_INPUTS; i++) begin
        node_re[N_INPUTS-1+i] <= pair_re[i];
        node_im[N_INPUTS-1+i] <= pair_im[i];
      end
    end
  end

  // Valid/sync side-pipe, same depth as the data path. Sync is only
  // meaningful on a valid sample, so it is qualified on entry.
  logic [LAT-1:0] valid_pipe, sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      sync_pipe  <= '0;
    end else begin
      valid_pipe <= {valid_pipe[LAT-2:0], in_valid};
      sync_pipe  <= {sync_pipe[LAT-2:0], in_valid & in_sync};
    end
  end

  assign sum_re    = node_re[0];
  assign sum_im    = node_im[0];
  assign sum_valid = valid_pipe[LAT-1];
  assign sum_sync  = sync_pipe[LAT-1];

endmodule

// File: rtl/xeng_cmac_acc.sv
// -----------------------------------------------------------------------------
// xeng_cmac_acc
// X-engine complex MAC: per valid cycle, sum of N_INPUTS complex products
// (a x conj(b) when CONJ_B=1, a x b otherwise), integrated over ACC_LEN valid
// cycles; one full-precision complex result is dumped per window.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     a/b carry a sample this cycle
//   in_sync      (with in_valid) this sample starts a new window
//   a, b         N_INPUTS packed {re, im} signed pairs, im in LSBs
//   out_valid    one-cycle pulse, ab holds a completed window
//   out_sync     with out_valid: first window after an in_sync
//   ab           {real, imag}, each OUT_WIDTH bits signed, held until next dump
//
// Derived widths: SUM_WIDTH = 2*BITWIDTH+1+N_INPUT_BITS,
//                 OUT_WIDTH = SUM_WIDTH+ACC_LEN_BITS.
// Latency: ACC_LEN-th valid sample -> out_valid is tree_latency+1 cycles.
// -----------------------------------------------------------------------------
module xeng_cmac_acc
  import xeng_pkg::*;
#(
  parameter int BITWIDTH     = 4,
  parameter int N_INPUT_BITS = 3,
  parameter int ACC_LEN_BITS = 4,
  parameter int CONJ_B       = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_valid,
  input  logic                                                 in_sync,
  input  logic [2*BITWIDTH*(1<<N_INPUT_BITS)-1:0]              a,
  input  logic [2*BITWIDTH*(1<<N_INPUT_BITS)-1:0]              b,
  output logic                                                 out_valid,
  output logic                                                 out_sync,
  output logic [2*out_width(BITWIDTH, N_INPUT_BITS, ACC_LEN_BITS)-1:0] ab
);

  localparam int SUM_WIDTH = sum_width(BITWIDTH, N_INPUT_BITS);
  localparam int OUT_WIDTH = out_width(BITWIDTH, N_INPUT_BITS, ACC_LEN_BITS);
  localparam int ACC_LEN   = 1 << ACC_LEN_BITS;
  // Keep the counter at least one bit wide so ACC_LEN==1 stays legal.
  localparam int CNT_W     = (ACC_LEN_BITS > 0) ? ACC_LEN_BITS : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic signed [SUM_WIDTH-1:0] sum_re, sum_im;
  logic                        sum_valid, sum_sync;

  xeng_cmult_tree #(
    .BITWIDTH     (BITWIDTH),
    .N_INPUT_BITS (N_INPUT_BITS),
    .CONJ_B       (CONJ_B)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .a         (a),
    .b         (b),
    .sum_re    (sum_re),
    .sum_im    (sum_im),
    .sum_valid (sum_valid),
    .sum_sync  (sum_sync)
  );

  logic [CNT_W-1:0]            cnt;
  logic                        win_sync;
  logic signed [OUT_WIDTH-1:0] acc_re, acc_im;

  // Window bookkeeping for the current tree sum. A window starts either
  // naturally (cnt==0) or on a sync, which discards any partial window:
  // the sum then loads rather than adds, and its position restarts at 0.
  logic                        start;
  logic                        last;
  logic [CNT_W-1:0]            pos;
  logic signed [OUT_WIDTH-1:0] base_re, base_im;
  logic signed [OUT_WIDTH-1:0] tot_re, tot_im;
  logic                        dump_sync;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here the
    // block is straight-line), so no latch can be inferred.
    start     = (cnt == '0) || sum_sync;
    pos       = start ? '0 : cnt;
    last      = (pos == CNT_LAST);
    base_re   = start ? '0 : acc_re;
    base_im   = start ? '0 : acc_im;
    tot_re    = base_re + OUT_WIDTH'(sum_re);
    tot_im    = base_im + OUT_WIDTH'(sum_im);
    dump_sync = start ? sum_sync : win_sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      win_sync  <= 1'b0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      ab        <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      if (sum_valid) begin
        cnt      <= last ? '0 : pos + CNT_W'(1);
        acc_re   <= tot_re;
        acc_im   <= tot_im;
        win_sync <= dump_sync;
        // The completing sum goes straight into ab, so a back-to-back
        // window can load the accumulator on the very next sum.
        if (last) begin
          out_valid                          <= 1'b1;
          out_sync                           <= dump_sync;
          ab[re_lsb(0, OUT_WIDTH) +: OUT_WIDTH] <= tot_re;
          ab[im_lsb(0, OUT_WIDTH) +: OUT_WIDTH] <= tot_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_xeng_cmac_acc.sv
// -----------------------------------------------------------------------------
// tb_xeng_cmac_acc
// Two instances share the stimulus: one with CONJ_B=1, one with CONJ_B=0.
// A sample-level model computes each window's complex sum directly from the
// input pairs and schedules the expected dump; a compare process checks both
// instances on every falling edge. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_xeng_cmac_acc;

  localparam int BW  = 4;
  localparam int NIB = 3;
  localparam int ALB = 4;
  localparam int NI  = 1 << NIB;
  localparam int AL  = 1 << ALB;
  localparam int OW  = 2 * BW + 1 + NIB + ALB;
  localparam int VW  = 2 * BW * NI;
  localparam int LAT = NIB + 3;  // in_valid cycle -> out_valid cycle

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic [VW-1:0] a = '0;
  logic [VW-1:0] b = '0;
  logic          ov_c, os_c, ov_n, os_n;
  logic [2*OW-1:0] ab_c, ab_n;

  always #5 clk = ~clk;

  xeng_cmac_acc #(.BITWIDTH(BW), .N_INPUT_BITS(NIB), .ACC_LEN_BITS(ALB), .CONJ_B(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .a(a), .b(b), .out_valid(ov_c), .out_sync(os_c), .ab(ab_c));

  xeng_cmac_acc #(.BITWIDTH(BW), .N_INPUT_BITS(NIB), .ACC_LEN_BITS(ALB), .CONJ_B(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .a(a), .b(b), .out_valid(ov_n), .out_sync(os_n), .ab(ab_n));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [BW-1:0] re, input logic [BW-1:0] im);
    return {NI{re, im}};
  endfunction

  function automatic longint part(input logic [VW-1:0] v, input int idx, input bit is_re);
    logic signed [BW-1:0] t;
    t = v[(2 * idx + (is_re ? 1 : 0)) * BW +: BW];
    return longint'(t);
  endfunction

  function automatic logic [2*OW-1:0] pack(input longint re, input longint im);
    logic [OW-1:0] r, i;
    r = re[OW-1:0];
    i = im[OW-1:0];
    return {r, i};
  endfunction

  // ---------------- model: one window = AL valid samples ----------------
  typedef struct {
    int     due;
    longint re_c, im_c, re_n, im_n;
    bit     sync;
  } dump_t;

  dump_t  exp_q[$];
  int     cyc = 0;
  int     w_cnt = 0;
  bit     w_sync = 1'b0;
  longint w_re_c = 0, w_im_c = 0, w_re_n = 0, w_im_n = 0;
  longint sr_c, si_c, sr_n, si_n, ar, ai, br, bi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      w_cnt = 0; w_sync = 1'b0;
      w_re_c = 0; w_im_c = 0; w_re_n = 0; w_im_n = 0;
    end else begin
      cyc++;
      if (in_valid) begin
        sr_c = 0; si_c = 0; sr_n = 0; si_n = 0;
        for (int i = 0; i < NI; i++) begin
          ar = part(a, i, 1); ai = part(a, i, 0);
          br = part(b, i, 1); bi = part(b, i, 0);
          sr_c += ar * br + ai * bi;
          si_c += ai * br - ar * bi;
          sr_n += ar * br - ai * bi;
          si_n += ai * br + ar * bi;
        end
        if (in_sync) begin
          w_cnt = 0;
          w_sync = 1'b1;
        end else if (w_cnt == 0) begin
          w_sync = 1'b0;
        end
        if (w_cnt == 0) begin
          w_re_c = 0; w_im_c = 0; w_re_n = 0; w_im_n = 0;
        end
        w_re_c += sr_c; w_im_c += si_c; w_re_n += sr_n; w_im_n += si_n;
        w_cnt++;
        if (w_cnt == AL) begin
          exp_q.push_back('{cyc + LAT - 1, w_re_c, w_im_c, w_re_n, w_im_n, w_sync});
          w_cnt = 0;
        end
      end
    end
  end

  // ---------------- compare + DUT observation ----------------
  logic [2*OW-1:0] held_c = '0, held_n = '0;
  dump_t  d;
  longint m_re_c = 0, m_im_c = 0;
  int     dut_dumps = 0, dut_sync_dumps = 0, dut_last_cyc = 0;
  int     dut_dump_cyc[$];
  bit     dut_last_sync = 1'b0;
  longint dut_re_c = 0, dut_im_c = 0, dut_re_n = 0, dut_im_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_c = '0;
      held_n = '0;
      check("reset out_valid conj", ov_c, 0);
      check("reset ab conj", ab_c, 0);
      check("reset out_valid plain", ov_n, 0);
      check("reset ab plain", ab_n, 0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        d = exp_q.pop_front();
        held_c = pack(d.re_c, d.im_c);
        held_n = pack(d.re_n, d.im_n);
        m_re_c = d.re_c;
        m_im_c = d.im_c;
        check("dump out_valid conj", ov_c, 1);
        check("dump ab conj", ab_c, held_c);
        check("dump out_sync conj", os_c, d.sync);
        check("dump out_valid plain", ov_n, 1);
        check("dump ab plain", ab_n, held_n);
        check("dump out_sync plain", os_n, d.sync);
      end else begin
        check("idle out_valid conj", ov_c, 0);
        check("idle out_sync conj", os_c, 0);
        check("hold ab conj", ab_c, held_c);
        check("idle out_valid plain", ov_n, 0);
        check("hold ab plain", ab_n, held_n);
      end
      if (ov_c) begin
        dut_dumps++;
        dut_sync_dumps += int'(os_c);
        dut_last_sync = os_c;
        dut_last_cyc = cyc;
        dut_dump_cyc.push_back(cyc);
        dut_re_c = longint'($signed(ab_c[2*OW-1:OW]));
        dut_im_c = longint'($signed(ab_c[OW-1:0]));
        dut_re_n = longint'($signed(ab_n[2*OW-1:OW]));
        dut_im_n = longint'($signed(ab_n[OW-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input bit s, input logic [VW-1:0] av, input logic [VW-1:0] bv);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sync  = s;
    a        = av;
    b        = bv;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [VW-1:0] a1, b1, am8, rav, rbv;
    int drv, base, base_s;
    a1  = rep(4'd1, 4'd2);
    b1  = rep(4'd3, 4'd4);
    am8 = rep(4'h8, 4'h8);
    drv = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", ov_c, 0);
    check("reset out_sync", os_c, 0);
    check("reset ab", ab_c, 0);
    rst_n = 1'b1;

    // Window running from reset with no sync: dumps, out_sync stays 0.
    base = dut_dumps;
    for (int i = 0; i < AL; i++) begin
      step(1'b1, 1'b0, a1, b1);
      drv = cyc;
    end
    idle(10);
    check("nosync dump count", dut_dumps - base, 1);
    check("nosync out_sync", dut_last_sync, 0);
    check("nosync ab re", dut_re_c, 1408);
    check("nosync latency", dut_last_cyc - drv, 6);

    // Single window started by sync: (1408,256) conj, (-640,1280) plain.
    base = dut_dumps;
    for (int i = 0; i < AL; i++) begin
      step(1'b1, i == 0, a1, b1);
      drv = cyc;
    end
    idle(10);
    check("s1 dump count", dut_dumps - base, 1);
    check("s1 ab re conj", dut_re_c, 1408);
    check("s1 ab im conj", dut_im_c, 256);
    check("s1 ab re plain", dut_re_n, -640);
    check("s1 ab im plain", dut_im_n, 1280);
    check("s1 out_sync", dut_last_sync, 1);
    check("s1 latency", dut_last_cyc - drv, 6);
    check("s1 model re", m_re_c, 1408);
    check("s1 model im", m_im_c, 256);

    // Extremes: every part -8.
    for (int i = 0; i < AL; i++) step(1'b1, i == 0, am8, am8);
    idle(10);
    check("ext ab re conj", dut_re_c, 16384);
    check("ext ab im conj", dut_im_c, 0);
    check("ext ab re plain", dut_re_n, 0);
    check("ext ab im plain", dut_im_n, 16384);

    // Gapped input: in_valid low every other cycle.
    base = dut_dumps;
    for (int i = 0; i < AL; i++) begin
      step(1'b1, i == 0, a1, b1);
      drv = cyc;
      step(1'b0, 1'b0, a1, b1);
    end
    idle(10);
    check("gap dump count", dut_dumps - base, 1);
    check("gap ab re conj", dut_re_c, 1408);
    check("gap ab im conj", dut_im_c, 256);
    check("gap latency", dut_last_cyc - drv, 6);

    // Mid-window sync: 7 samples of a different value are dropped.
    base = dut_dumps;
    for (int i = 0; i < 7 + AL; i++) begin
      if (i < 7) step(1'b1, i == 0, am8, am8);
      else       step(1'b1, i == 7, a1, b1);
      drv = cyc;
    end
    idle(10);
    check("midsync dump count", dut_dumps - base, 1);
    check("midsync ab re conj", dut_re_c, 1408);
    check("midsync ab im conj", dut_im_c, 256);
    check("midsync out_sync", dut_last_sync, 1);
    check("midsync latency", dut_last_cyc - drv, 6);

    // Back-to-back: 48 continuous pseudo-random samples.
    base = dut_dumps;
    base_s = dut_sync_dumps;
    dut_dump_cyc.delete();
    for (int i = 0; i < 3 * AL; i++) begin
      rav = {$urandom, $urandom};
      rbv = {$urandom, $urandom};
      step(1'b1, i == 0, rav, rbv);
      if (i == AL - 1) drv = cyc;
    end
    idle(10);
    check("b2b dump count", dut_dumps - base, 3);
    check("b2b sync dumps", dut_sync_dumps - base_s, 1);
    if (dut_dump_cyc.size() == 3) begin
      check("b2b first latency", dut_dump_cyc[0] - drv, 6);
      check("b2b spacing 1", dut_dump_cyc[1] - dut_dump_cyc[0], AL);
      check("b2b spacing 2", dut_dump_cyc[2] - dut_dump_cyc[1], AL);
    end

    // Reset mid-window after 9 samples.
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, am8, am8);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("async reset out_valid", ov_c, 0);
    check("async reset ab conj", ab_c, 0);
    check("async reset ab plain", ab_n, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = dut_dumps;
    for (int i = 0; i < AL; i++) begin
      step(1'b1, i == 0, a1, b1);
      drv = cyc;
    end
    idle(10);
    check("post-reset dump count", dut_dumps - base, 1);
    check("post-reset ab re conj", dut_re_c, 1408);
    check("post-reset ab im conj", dut_im_c, 256);
    check("post-reset out_sync", dut_last_sync, 1);
    check("post-reset latency", dut_last_cyc - drv, 6);

    check("pending dumps", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
